seq_shift_unit: RTL and testbench
=================================

// Module: seq_shift_unit
// PURPOSE
//   Parametrised multi-cycle shifter for the CPU datapath: logical left, logical right,
//   arithmetic right and rotate right, with a configurable amount per cycle.
//   Sits beside the ALU; the control unit issues START and stalls on BUSY until DONE.
//   Replaces the fixed 8-bit combinational left shifter.
//   Shift amount is taken from the instruction immediate.
// PARAMETERS
//   WIDTH  8  data width in bits; >= 2, power of 2
//   AMT_W  8  width of the AMOUNT port
//   STEP   1  bits shifted per cycle; power of 2, 1..WIDTH
// PORTS
//   CLK      in   1      rising-edge clock
//   RESET_N  in   1      asynchronous, active-low reset
//   START    in   1      request; sampled only when BUSY=0
//   VALUE    in   WIDTH  operand, latched on accept
//   AMOUNT   in   AMT_W  unsigned shift amount, latched on accept
//   MODE     in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR; latched on accept
//   BUSY     out  1      operation in progress
//   DONE     out  1      one-cycle pulse: RESULT valid
//   RESULT   out  WIDTH  shifted value; holds until the next accept
// BEHAVIOUR
//   Reset (RESET_N=0, takes effect immediately, no clock needed):
//   - State goes to IDLE; BUSY=0, DONE=0, RESULT=0.
//   - Any operation in flight is discarded.
//   States:
//   - IDLE: START=1 at an edge -> accept. Latch VALUE, MODE and EFF; go to SHIFT; BUSY=1.
//   - SHIFT: each edge shifts the working register by k = min(STEP, REM) bits; REM -= k.
//     When REM reaches 0 at an edge: copy the working register to RESULT, DONE=1,
//     BUSY=0, go to IDLE.
//   - EFF=0 spends one no-op SHIFT cycle.
//   Effective amount (EFF):
//   - SLL/SRL/SRA: EFF = min(AMOUNT, WIDTH). AMOUNT >= WIDTH gives 0 for SLL/SRL
//     and all copies of the sign bit for SRA.
//   - ROR: EFF = AMOUNT mod WIDTH.
//   Fill rules:
//   - SLL fills the LSBs with 0; SRL fills the MSBs with 0.
//   - SRA fills the MSBs with the original VALUE[WIDTH-1].
//   - ROR moves the LSBs into the MSBs.
//   Latency (accept at edge 0):
//   - DONE is high in the cycle after edge N, where N = max(1, ceil(EFF/STEP)).
//   - BUSY is high in cycles 1..N.
//   Handshake:
//   - START is ignored while BUSY=1; inputs may change freely after accept.
//   - DONE is never asserted for more than one cycle.
//   - START high in the DONE cycle is accepted (BUSY=0), so back-to-back operations
//     run with no idle cycle.
//   - RESULT changes only on the completing edge; it is stable from DONE until the
//     next completion.
//   Arithmetic is unsigned on AMOUNT. No X is propagated from undriven MODE bits;
//   all four codes are defined.
// TESTING  (WIDTH=8, STEP=1 unless stated)
//   1. SLL 0x81 by 3 -> RESULT 0x08; BUSY for 3 cycles; DONE pulses once, 4th cycle after accept.
//   2. SRA 0x90 by 2 -> 0xE4. SRA 0x90 by 200 -> 0xFF after 8 busy cycles.
//      SRL 0x90 by 200 -> 0x00.
//   3. ROR 0x81 by 9 -> EFF=1 -> 0xC0 after 1 busy cycle. ROR 0x81 by 8 -> 0x81 after 1 cycle.
//   4. SRL 0xF0 by 0 -> 0xF0, DONE after 1 busy cycle.
//      START pulsed mid-operation -> ignored, RESULT unchanged.
//   5. START held high continuously with SLL 0x01 by 1 -> DONE every 2nd cycle;
//      RESULT 0x02 each time, no lost or duplicated DONE.
//   6. RESET_N low during cycle 2 of SLL by 5 -> BUSY/DONE/RESULT 0 at once, no DONE later.
//      STEP=4: SLL 0x01 by 7 -> 0x80 in 2 busy cycles.

Source files
------------

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_unit
// Description : Multi-cycle shifter for the CPU datapath. Supports logical
//               left, logical right, arithmetic right and rotate right. It
//               shifts by up to STEP bits per clock. Operands are latched on
//               accept. The control unit stalls on busy and consumes the
//               one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
  parameter int WIDTH = 8,  // data width, power of 2, >= 2
  parameter int AMT_W = 8,  // width of the amount port
  parameter int STEP  = 1   // bits shifted per cycle, power of 2, 1..WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Remaining-count width must be able to hold WIDTH itself (SLL/SRL/SRA saturate there)
  localparam int c_cnt_w = $clog2(WIDTH + 1);

  localparam logic [c_cnt_w-1:0] c_step  = c_cnt_w'(STEP);
  localparam logic [c_cnt_w-1:0] c_width = c_cnt_w'(WIDTH);

  localparam logic [1:0] c_mode_sll = 2'b00;
  localparam logic [1:0] c_mode_srl = 2'b01;
  localparam logic [1:0] c_mode_sra = 2'b10;
  localparam logic [1:0] c_mode_ror = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [c_cnt_w-1:0] r_rem;
  logic [1:0]         r_mode;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic [31:0]        w_amt_ext;
  logic [c_cnt_w-1:0] w_eff;
  logic [c_cnt_w-1:0] w_k;
  logic [c_cnt_w-1:0] w_rem_nxt;
  logic [2*WIDTH-1:0] w_rot;
  logic [WIDTH-1:0]   w_shifted;

  // Effective amount: rotate wraps modulo WIDTH, the other modes saturate at WIDTH
  always_comb begin
    w_amt_ext = 32'(amount);
    if (mode == c_mode_ror) begin
      w_eff = c_cnt_w'(w_amt_ext & 32'(WIDTH - 1));
    end else if (w_amt_ext >= 32'(WIDTH)) begin
      w_eff = c_width;
    end else begin
      w_eff = c_cnt_w'(w_amt_ext);
    end
  end

  // One shift step of min(STEP, remaining) bits on the working register
  always_comb begin
    w_k       = (r_rem > c_step) ? c_step : r_rem;
    w_rem_nxt = r_rem - w_k;
    // Rotate never sees k == WIDTH because its effective amount is below WIDTH
    w_rot     = {r_work, r_work} >> w_k;
    case (r_mode)
      c_mode_sll: w_shifted = r_work << w_k;
      c_mode_srl: w_shifted = r_work >> w_k;
      // MSB of the working register always still holds the original sign bit
      c_mode_sra: w_shifted = $signed(r_work) >>> w_k;
      default:    w_shifted = w_rot[WIDTH-1:0];
    endcase
  end

  // Control FSM: accept in IDLE, step in SHIFT, publish result on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_rem    <= '0;
      r_mode   <= c_mode_sll;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle is also an IDLE cycle, so back-to-back starts are accepted
          if (start) begin
            r_work  <= value;
            r_mode  <= mode;
            r_rem   <= w_eff;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_nxt;
          // A zero effective amount completes here too, giving one no-op cycle
          if (w_rem_nxt == '0) begin
            r_result <= w_shifted;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_unit
// Description : Self-checking bench for seq_shift_unit. It runs one STEP=1
//               instance and one STEP=4 instance side by side. Both are
//               checked cycle by cycle against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_unit;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] value  = '0;
  logic [7:0] amount = '0;
  logic [1:0] mode   = '0;

  logic       busy1, done1, busy4, done4;
  logic [7:0] result1, result4;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] prev1   = '0;
  logic [7:0] prev4   = '0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(8), .AMT_W(8), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .value(value), .amount(amount),
    .mode(mode), .busy(busy1), .done(done1), .result(result1)
  );

  seq_shift_unit #(.WIDTH(8), .AMT_W(8), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .value(value), .amount(amount),
    .mode(mode), .busy(busy4), .done(done4), .result(result4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain integer arithmetic
  function automatic logic [7:0] ref_result(input logic [1:0] m, input logic [7:0] v, input int a);
    int sv;
    int e;
    case (m)
      2'd0: return (a >= 8) ? 8'h00 : 8'(int'(v) << a);
      2'd1: return (a >= 8) ? 8'h00 : 8'(int'(v) >> a);
      2'd2: begin
        sv = int'(v);
        if (v[7]) sv = sv - 256;
        e = (a >= 8) ? 8 : a;
        return 8'(sv >>> e);
      end
      default: begin
        e = a % 8;
        return 8'((int'(v) >> e) | (int'(v) << (8 - e)));
      end
    endcase
  endfunction

  // Busy cycles N = max(1, ceil(EFF/STEP))
  function automatic int ref_cycles(input logic [1:0] m, input int a, input int step);
    int e;
    e = (m == 2'd3) ? (a % 8) : ((a > 8) ? 8 : a);
    return (e == 0) ? 1 : (e + step - 1) / step;
  endfunction

  // One operation on both instances; optional mid-operation start pulse on dut1
  task automatic run_op(input logic [1:0] m, input logic [7:0] v, input int a,
                        input bit poke, input int want);
    logic [7:0] exp;
    logic [7:0] er;
    logic       eb, ed;
    int n1, n4, last;
    exp  = ref_result(m, v, a);
    n1   = ref_cycles(m, a, 1);
    n4   = ref_cycles(m, a, 4);
    last = ((n1 > n4) ? n1 : n4) + 2;
    @(negedge clk);
    mode = m; value = v; amount = 8'(a); start1 = 1'b1; start4 = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start1 = 1'b0; start4 = 1'b0;
        value = 8'($urandom); amount = 8'($urandom); mode = 2'($urandom);
      end
      eb = (c <= n1); ed = (c == n1 + 1); er = (c <= n1) ? prev1 : exp;
      chk($sformatf("s1 m%0d v%02h a%0d c%0d", m, v, a, c), {busy1, done1, result1}, {eb, ed, er});
      eb = (c <= n4); ed = (c == n4 + 1); er = (c <= n4) ? prev4 : exp;
      chk($sformatf("s4 m%0d v%02h a%0d c%0d", m, v, a, c), {busy4, done4, result4}, {eb, ed, er});
      if (poke && c == 3) begin
        start1 = 1'b1; value = 8'($urandom); amount = 8'($urandom_range(1, 8));
      end
      if (c == 4) start1 = 1'b0;
    end
    if (want >= 0) chk($sformatf("lit m%0d v%02h a%0d", m, v, a), result1, want);
    prev1 = exp;
    prev4 = exp;
  endtask

  // Start held high: dut1 completes every second cycle, always with 0x02
  task automatic run_b2b();
    logic ed;
    @(negedge clk);
    mode = 2'd0; value = 8'h01; amount = 8'd1; start1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ed = (c % 2 == 0);
      chk($sformatf("b2b c%0d", c), {busy1, done1, result1},
          {~ed, ed, (c >= 2) ? 8'h02 : prev1});
    end
    start1 = 1'b0;
    prev1  = 8'h02;
  endtask

  // Asynchronous reset in cycle 2 of SLL by 5 on both instances
  task automatic run_reset();
    @(negedge clk);
    mode = 2'd0; value = 8'h81; amount = 8'd5; start1 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    chk("rst pre busy1", busy1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst s1", {busy1, done1, result1}, 10'h000);
    chk("rst s4", {busy4, done4, result4}, 10'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("post rst s1 c%0d", c), {busy1, done1, result1}, 10'h000);
      chk($sformatf("post rst s4 c%0d", c), {busy4, done4, result4}, 10'h000);
    end
    prev1 = '0;
    prev4 = '0;
  endtask

  initial begin
    logic [1:0] m;
    logic [7:0] v;
    int         a;
    #1 rst_n = 1'b0;
    #2;
    chk("reset s1", {busy1, done1, result1}, 10'h000);
    chk("reset s4", {busy4, done4, result4}, 10'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 8'h81, 3,   1'b0, 8'h08);
    run_op(2'd2, 8'h90, 2,   1'b0, 8'hE4);
    run_op(2'd2, 8'h90, 200, 1'b1, 8'hFF);
    run_op(2'd1, 8'h90, 200, 1'b0, 8'h00);
    run_op(2'd3, 8'h81, 9,   1'b0, 8'hC0);
    run_op(2'd3, 8'h81, 8,   1'b0, 8'h81);
    run_op(2'd1, 8'hF0, 0,   1'b0, 8'hF0);
    run_op(2'd0, 8'h01, 7,   1'b1, 8'h80);
    run_b2b();
    run_reset();

    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      v = 8'($urandom);
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      run_op(m, v, a, (ref_cycles(m, a, 1) >= 4) && ($urandom_range(0, 1) == 1), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
